key_pulse_gen: RTL and testbench
================================

Name: key_pulse_gen

Overview:
Conditions one raw push-button for the clock's mode and setting logic. It synchronises and debounces the button, then emits a single-cycle PULSE per press. Optionally, it emits auto-repeat pulses while the button is held. PULSE drives the MODE input of the display-mode state machine and the set/increment inputs of the time-setting logic.

Parameters:
DEBOUNCE_CYCLES, 500000, cycles the synchronised input must stay stable to accept a press or release (10 ms at 50 MHz); must be >= 2.
REPEAT_EN, 0, 1 enables auto-repeat while held.
REPEAT_DELAY, 25000000, cycles from the first PULSE to the first repeat PULSE; must be >= 2.
REPEAT_PERIOD, 10000000, cycles between successive repeat PULSEs; must be >= 2.
KEY_ACTIVE_LOW, 1, 1 means the board button reads 0 when pressed.
CNT_W, 25, counter width; must be >= clog2 of the largest cycle parameter.

Ports:
CLK  input  1  system clock, rising edge.
RESET  input  1  reset, asynchronous, active-low (0 = reset).
KEY_IN  input  1  raw asynchronous button level.
EN  input  1  pulse enable; 0 suppresses PULSE only, the FSM keeps running.
PULSE  output  1  one-cycle press/repeat strobe, registered.
KEY_LEVEL  output  1  debounced pressed level, registered.
LONG  output  1  high while in auto-repeat, registered.

Behaviour:
- Polarity: k = KEY_IN xor KEY_ACTIVE_LOW. Then k passes through a 2-flop synchroniser giving key_s. Both flops reset to 0.
- Reset (RESET=0, asynchronous): state=IDLE, counter=0, PULSE=0, KEY_LEVEL=0, LONG=0, synchroniser=0. Reset asserted mid-operation aborts the current press; no PULSE is emitted on reset release.
- FSM (one-hot, 5 states) and counter cnt:
  - IDLE: if key_s=1, go to DB_PRESS with cnt=1; otherwise stay with cnt=0.
  - DB_PRESS: if key_s=0, go to IDLE with cnt=0 (glitch rejected, no PULSE). Else if cnt=DEBOUNCE_CYCLES-1, go to HELD with cnt=0, KEY_LEVEL<=1, PULSE<=EN. Else cnt+1.
  - HELD: if key_s=0, go to DB_RELEASE with cnt=1. Else if REPEAT_EN and cnt=REPEAT_DELAY-1, go to REPEAT with cnt=0, PULSE<=EN, LONG<=1. Else cnt+1. With REPEAT_EN=0, cnt saturates and never wraps.
  - REPEAT: if key_s=0, go to DB_RELEASE with cnt=1 and LONG<=0. Else if cnt=REPEAT_PERIOD-1, cnt=0 and PULSE<=EN. Else cnt+1.
  - DB_RELEASE: if key_s=1, go to HELD with cnt=0 (release bounce, no PULSE, repeat delay restarts). Else if cnt=DEBOUNCE_CYCLES-1, go to IDLE with cnt=0 and KEY_LEVEL<=0. Else cnt+1.
  - Illegal or non-one-hot state: go to IDLE next cycle with outputs cleared.
- PULSE is high for exactly one cycle per event and is never high on two consecutive cycles.
- Latency: KEY_IN held pressed from clock edge e0 gives PULSE high during the cycle after edge e0+DEBOUNCE_CYCLES+2. KEY_LEVEL rises in the same cycle as PULSE.
- First repeat PULSE comes REPEAT_DELAY cycles after the first PULSE; later repeats come every REPEAT_PERIOD cycles.
- EN=0 coincident with an event: that PULSE is lost, not deferred; KEY_LEVEL and LONG are unaffected.
- Release takes priority over a repeat-count match in the same cycle: no PULSE is emitted.

Decomposition:
- Shared package: the 5 one-hot state constants (IDLE, DB_PRESS, HELD, REPEAT, DB_RELEASE) and the default cycle constants for 50 MHz.
- One sub-module, sync_2ff (2-flop synchroniser, asynchronous active-low reset), reused for every board input.

Test Plan:
(Bench parameters: DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3, KEY_ACTIVE_LOW=1, EN=1.)
1. Clean press: KEY_IN 1->0 held for 40 cycles, REPEAT_EN=0 -> exactly one PULSE, 6 cycles after the first active sample. KEY_LEVEL=1 until 6 cycles after release. LONG stays 0.
2. Bounce: KEY_IN pressed for 2 cycles, 1 cycle open, then 3 cycles pressed, then open -> no PULSE, KEY_LEVEL stays 0.
3. Auto-repeat: REPEAT_EN=1, hold for 30 cycles -> PULSE at t, t+10, t+13, t+16, ..., ending with the last repeat before release. LONG=1 from t+10 until release is seen.
4. Release bounce: while HELD, KEY_IN released for 2 cycles then pressed again -> no second PULSE, KEY_LEVEL stays 1, repeat delay restarts.
5. EN gating: EN=0 during a full press -> PULSE=0 throughout, KEY_LEVEL still toggles. EN=1 on the next press -> one PULSE.
6. Reset mid-press: drive RESET=0 while in DB_PRESS, release RESET with the key still pressed -> all outputs 0 during reset. After release, a full debounce (6 cycles) occurs before the single PULSE.

Source files
------------

// File: rtl/key_pulse_gen_pkg.sv
// -----------------------------------------------------------------------------
// key_pulse_gen_pkg
// Shared definitions for the push-button pulse generator:
//   - one-hot state encoding of the press/repeat/release state machine
//   - default cycle counts for a 50 MHz system clock
// -----------------------------------------------------------------------------
package key_pulse_gen_pkg;

    // One-hot states. Any other bit pattern is treated as illegal and recovers
    // to ST_IDLE on the next clock.
    typedef enum logic [4:0] {
        ST_IDLE       = 5'b00001,
        ST_DB_PRESS   = 5'b00010,
        ST_HELD       = 5'b00100,
        ST_REPEAT     = 5'b01000,
        ST_DB_RELEASE = 5'b10000
    } state_e;

    // Defaults for a 50 MHz clock: 10 ms debounce, 0.5 s first repeat,
    // 0.2 s repeat period. A 25-bit counter covers the largest of these.
    localparam int DEF_DEBOUNCE_CYCLES = 500000;
    localparam int DEF_REPEAT_DELAY    = 25000000;
    localparam int DEF_REPEAT_PERIOD   = 10000000;
    localparam int DEF_CNT_W           = 25;

endpackage : key_pulse_gen_pkg

// File: rtl/key_pulse_gen_sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Two-flop synchroniser for asynchronous board inputs, one independent
// chain per bit. Both flop stages clear to 0 under reset.
// Ports:
//   clk_i   : destination clock, rising edge
//   rst_ni  : asynchronous active-low reset
//   d_i     : asynchronous input bits
//   q_o     : synchronised bits (two clocks of latency)
// -----------------------------------------------------------------------------
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    meta_q[gi] <= 1'b0;
                    sync_q[gi] <= 1'b0;
                end else begin
                    meta_q[gi] <= d_i[gi];
                    sync_q[gi] <= meta_q[gi];
                end
            end
        end
    endgenerate

    assign q_o = sync_q;

endmodule : sync_2ff

// File: rtl/key_pulse_gen.sv
// -----------------------------------------------------------------------------
// key_pulse_gen
// Conditions one raw push-button: polarity correction, 2-flop synchronisation,
// press/release debouncing, a one-cycle PULSE per accepted press and optional
// auto-repeat PULSEs while the button stays held.
// Ports:
//   CLK       : system clock, rising edge
//   RESET     : asynchronous active-low reset
//   KEY_IN    : raw asynchronous button level
//   EN        : pulse enable; 0 drops the PULSE of that cycle, FSM unaffected
//   PULSE     : one-cycle press/repeat strobe (registered)
//   KEY_LEVEL : debounced pressed level (registered)
//   LONG      : high while auto-repeating (registered)
// -----------------------------------------------------------------------------
module key_pulse_gen
    import key_pulse_gen_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_EN       = 0,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
    parameter int KEY_ACTIVE_LOW  = 1,
    parameter int CNT_W           = DEF_CNT_W
) (
    input  logic CLK,
    input  logic RESET,
    input  logic KEY_IN,
    input  logic EN,
    output logic PULSE,
    output logic KEY_LEVEL,
    output logic LONG
);

    localparam logic             KEY_INV  = (KEY_ACTIVE_LOW != 0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RP_LAST  = CNT_W'(REPEAT_PERIOD - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic             RPT_ON   = (REPEAT_EN != 0);

    // ------------------------------------------------------------------
    // Polarity correction ahead of the synchroniser so key_s is 1 = pressed
    // ------------------------------------------------------------------
    logic key_raw;
    logic key_s;

    assign key_raw = KEY_IN ^ KEY_INV;

    sync_2ff #(
        .WIDTH (1)
    ) u_sync_key (
        .clk_i  (CLK),
        .rst_ni (RESET),
        .d_i    (key_raw),
        .q_o    (key_s)
    );

    // ------------------------------------------------------------------
    // State machine
    // ------------------------------------------------------------------
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pulse_q, pulse_d;
    logic             level_q, level_d;
    logic             long_q, long_d;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
            level_q <= 1'b0;
            long_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
            level_q <= level_d;
            long_q  <= long_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pulse_d = 1'b0;
        level_d = level_q;
        long_d  = long_q;

        case (state_q)
            ST_IDLE: begin
                if (key_s) begin
                    state_d = ST_DB_PRESS;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d   = '0;
                end
            end

            ST_DB_PRESS: begin
                if (!key_s) begin
                    // Press glitch shorter than the debounce window
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == DB_LAST) begin
                    state_d = ST_HELD;
                    cnt_d   = '0;
                    level_d = 1'b1;
                    pulse_d = EN;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end

            ST_HELD: begin
                if (!key_s) begin
                    state_d = ST_DB_RELEASE;
                    cnt_d   = CNT_ONE;
                end else if (RPT_ON && (cnt_q == RD_LAST)) begin
                    state_d = ST_REPEAT;
                    cnt_d   = '0;
                    pulse_d = EN;
                    long_d  = 1'b1;
                end else if (cnt_q != CNT_MAX) begin
                    // Saturate so a very long hold never wraps into a repeat
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end

            ST_REPEAT: begin
                // Release is checked first so it wins over a period match
                if (!key_s) begin
                    state_d = ST_DB_RELEASE;
                    cnt_d   = CNT_ONE;
                    long_d  = 1'b0;
                end else if (cnt_q == RP_LAST) begin
                    cnt_d   = '0;
                    pulse_d = EN;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end

            ST_DB_RELEASE: begin
                if (key_s) begin
                    // Release bounce: back to held, repeat delay starts over
                    state_d = ST_HELD;
                    cnt_d   = '0;
                end else if (cnt_q == DB_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    level_d = 1'b0;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end

            default: begin
                // Non-one-hot state: recover cleanly
                state_d = ST_IDLE;
                cnt_d   = '0;
                level_d = 1'b0;
                long_d  = 1'b0;
            end
        endcase
    end

    assign PULSE     = pulse_q;
    assign KEY_LEVEL = level_q;
    assign LONG      = long_q;

endmodule : key_pulse_gen

// File: tb/tb_key_pulse_gen.sv
// -----------------------------------------------------------------------------
// tb_key_pulse_gen
// Two instances share one stimulus: index 0 without auto-repeat, index 1 with
// auto-repeat. A behavioural model counts consecutive pressed/released samples
// and hold time to predict PULSE / KEY_LEVEL / LONG every cycle.
// -----------------------------------------------------------------------------
module tb_key_pulse_gen;

    localparam int D  = 4;
    localparam int RD = 10;
    localparam int RP = 3;

    logic CLK    = 1'b0;
    logic RESET  = 1'b0;
    logic KEY_IN = 1'b1;
    logic EN     = 1'b1;

    logic pulse0, level0, long0;
    logic pulse1, level1, long1;

    always #5 CLK = ~CLK;

    key_pulse_gen #(
        .DEBOUNCE_CYCLES (D),
        .REPEAT_EN       (0),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP),
        .KEY_ACTIVE_LOW  (1),
        .CNT_W           (8)
    ) dut_norep (
        .CLK       (CLK),
        .RESET     (RESET),
        .KEY_IN    (KEY_IN),
        .EN        (EN),
        .PULSE     (pulse0),
        .KEY_LEVEL (level0),
        .LONG      (long0)
    );

    key_pulse_gen #(
        .DEBOUNCE_CYCLES (D),
        .REPEAT_EN       (1),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP),
        .KEY_ACTIVE_LOW  (1),
        .CNT_W           (8)
    ) dut_rep (
        .CLK       (CLK),
        .RESET     (RESET),
        .KEY_IN    (KEY_IN),
        .EN        (EN),
        .PULSE     (pulse1),
        .KEY_LEVEL (level1),
        .LONG      (long1)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit p1, p2;            // model of the two synchroniser delays
    bit m_lvl   [2];
    bit m_long  [2];
    bit m_pulse [2];
    int m_run   [2];       // consecutive samples opposite to the debounced level
    int m_age   [2];       // samples held since press / bounce / last repeat
    int cyc = 0;
    int seen_cnt [2];      // DUT pulses observed

    task automatic model_reset();
        p1 = 0; p2 = 0;
        for (int i = 0; i < 2; i++) begin
            m_lvl[i] = 0; m_long[i] = 0; m_pulse[i] = 0;
            m_run[i] = 0; m_age[i] = 0;
        end
    endtask

    task automatic model_edge(input bit act, input bit en);
        bit s;
        s  = p2;
        p2 = p1;
        p1 = act;
        for (int i = 0; i < 2; i++) begin
            m_pulse[i] = 0;
            if (!m_lvl[i]) begin
                if (s) begin
                    m_run[i]++;
                    if (m_run[i] == D) begin
                        m_lvl[i] = 1; m_run[i] = 0; m_age[i] = 0; m_long[i] = 0;
                        m_pulse[i] = en;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end else if (!s) begin
                m_run[i]++;
                m_long[i] = 0;
                if (m_run[i] == D) begin
                    m_lvl[i] = 0; m_run[i] = 0;
                end
            end else if (m_run[i] > 0) begin
                m_run[i] = 0;
                m_age[i] = 0;
            end else begin
                m_age[i]++;
                if (i == 1) begin
                    if ((!m_long[i] && m_age[i] == RD) || (m_long[i] && m_age[i] == RP)) begin
                        m_pulse[i] = en;
                        m_long[i]  = 1;
                        m_age[i]   = 0;
                    end
                end
            end
        end
    endtask

    // One clock: drive inputs, let the edge happen, compare after it.
    task automatic step(input bit pressed, input bit en);
        KEY_IN = ~pressed;
        EN     = en;
        @(posedge CLK);
        model_edge(pressed, en);
        #1;
        cyc++;
        chk("pulse_norep", pulse0, m_pulse[0]);
        chk("level_norep", level0, m_lvl[0]);
        chk("long_norep",  long0,  m_long[0]);
        chk("pulse_rep",   pulse1, m_pulse[1]);
        chk("level_rep",   level1, m_lvl[1]);
        chk("long_rep",    long1,  m_long[1]);
        if (pulse0 === 1'b1) seen_cnt[0]++;
        if (pulse1 === 1'b1) seen_cnt[1]++;
    endtask

    task automatic do_reset(input bit pressed);
        KEY_IN = ~pressed;
        RESET  = 1'b0;
        #1;
        chk("rst_pulse", {pulse0, pulse1}, 0);
        chk("rst_level", {level0, level1}, 0);
        chk("rst_long",  {long0,  long1},  0);
        @(posedge CLK);
        @(posedge CLK);
        #1;
        chk("rst_hold", {pulse0, pulse1, level0, level1, long0, long1}, 0);
        RESET = 1'b1;
        model_reset();
    endtask

    initial begin
        int first, cnt0, cnt1, minlvl, maxlvl;
        model_reset();
        do_reset(0);
        repeat (5) step(0, 1);

        // 1: clean press, latency D+2 to PULSE and to KEY_LEVEL fall
        first = -1; cnt0 = seen_cnt[0];
        for (int k = 1; k <= 40; k++) begin
            step(1, 1);
            if (pulse0 === 1'b1 && first < 0) first = k;
        end
        chk("t1_latency", first, D + 2);
        chk("t1_pulses", seen_cnt[0] - cnt0, 1);
        first = -1;
        for (int k = 1; k <= 12; k++) begin
            step(0, 1);
            if (level0 === 1'b0 && first < 0) first = k;
        end
        chk("t1_release", first, D + 2);

        // 2: press bounce shorter than debounce
        cnt0 = seen_cnt[0]; cnt1 = seen_cnt[1]; maxlvl = 0;
        repeat (2) step(1, 1);
        step(0, 1);
        repeat (3) step(1, 1);
        for (int k = 0; k < 10; k++) begin
            step(0, 1);
            if (level0 === 1'b1 || level1 === 1'b1) maxlvl = 1;
        end
        chk("t2_pulses", seen_cnt[0] - cnt0 + seen_cnt[1] - cnt1, 0);
        chk("t2_level", maxlvl, 0);

        // 3: auto-repeat; pulses at edges 6,16,19,22,25,28,31 of a 30-cycle hold
        cnt1 = seen_cnt[1];
        for (int k = 1; k <= 30; k++) begin
            step(1, 1);
            if (k == 15) chk("t3_long_before", long1, 0);
            if (k == 16) chk("t3_long_at", long1, 1);
        end
        repeat (12) step(0, 1);
        chk("t3_pulses", seen_cnt[1] - cnt1, 7);

        // 4: release bounce while held restarts the repeat delay
        cnt1 = seen_cnt[1]; first = -1; minlvl = 1;
        for (int k = 1; k <= 30; k++) begin
            step((k <= 8 || k >= 11) ? 1'b1 : 1'b0, 1);
            if (k >= 7 && k <= 22 && level1 !== 1'b1) minlvl = 0;
            if (k == 20) chk("t4_no_second", seen_cnt[1] - cnt1, 1);
            if (k > 6 && pulse1 === 1'b1 && first < 0) first = k;
        end
        chk("t4_level", minlvl, 1);
        chk("t4_restart", first, 23);
        repeat (12) step(0, 1);

        // 5: EN gating
        cnt0 = seen_cnt[0]; cnt1 = seen_cnt[1]; maxlvl = 0;
        for (int k = 0; k < 20; k++) begin
            step(1, 0);
            if (level0 === 1'b1) maxlvl = 1;
        end
        repeat (12) step(0, 0);
        chk("t5_gated", seen_cnt[0] - cnt0 + seen_cnt[1] - cnt1, 0);
        chk("t5_level", maxlvl, 1);
        chk("t5_level_back", level0, 0);
        cnt0 = seen_cnt[0];
        repeat (20) step(1, 1);
        repeat (12) step(0, 1);
        chk("t5_enabled", seen_cnt[0] - cnt0, 1);

        // 6: reset during press debounce, full debounce after release
        repeat (3) step(1, 1);
        do_reset(1);
        first = -1; cnt0 = seen_cnt[0];
        for (int k = 1; k <= 12; k++) begin
            step(1, 1);
            if (pulse0 === 1'b1 && first < 0) first = k;
        end
        chk("t6_latency", first, D + 2);
        chk("t6_pulses", seen_cnt[0] - cnt0, 1);
        repeat (12) step(0, 1);

        // Random bursts with bouncing, EN drops and occasional resets
        for (int e = 0; e < 150; e++) begin
            bit lvl;
            int len;
            lvl = $urandom_range(0, 1);
            len = (($urandom_range(0, 3)) == 0) ? $urandom_range(1, 3) : $urandom_range(4, 30);
            for (int k = 0; k < len; k++)
                step(lvl, ($urandom_range(0, 7) != 0));
            if ($urandom_range(0, 24) == 0) do_reset($urandom_range(0, 1));
        end
        repeat (12) step(0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_key_pulse_gen
